mem_boot_seq: RTL and testbench
===============================

Name: mem_boot_seq

Overview:
- Hardware sequencer that boots the cpu core through its external memory ports.
- Streams a host image into data memory, then instruction memory, then asserts cpu enable.
- Watches the fetched instruction for the STOP opcode, or a cycle timeout.
- Reads back a window of data memory to the host over a valid/ready stream.
- Sits between the host/test harness and the cpu addr_ext/addr_ext_2 ports; replaces ad-hoc load/dump sequencing.

Parameters:
- IMEM_WORDS, 128, 32-bit words written to instruction memory.
- DMEM_WORDS, 128, 64-bit words written to data memory.
- TIMEOUT, 99999, run-cycle limit.
- CNT_W, 32, cycle counter width.
- STOP_OPC, 7'b1111110, instruction[6:0] value that ends a run.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a boot; honoured only in IDLE.
- dump_base  in  7  first dmem word index to dump; sampled on start.
- dump_len  in  8  number of words to dump; sampled on start.
- host_valid  in  1  host word valid.
- host_ready  out  1  sequencer accepts host word.
- host_data  in  64  image word; bits [31:0] are used in the imem phase.
- imem_wen  out  1  to cpu wen_ext.
- imem_addr  out  64  to cpu addr_ext.
- imem_wdata  out  32  to cpu wdata_ext.
- dmem_wen  out  1  to cpu wen_ext_2.
- dmem_ren  out  1  to cpu ren_ext_2.
- dmem_addr  out  64  to cpu addr_ext_2.
- dmem_wdata  out  64  to cpu wdata_ext_2.
- dmem_rdata  in  64  from cpu rdata_ext_2.
- cpu_instr  in  32  current fetched instruction.
- cpu_enable  out  1  to cpu enable.
- out_valid  out  1  dump word valid.
- out_ready  in  1  host accepts dump word.
- out_data  out  64  dump word.
- cycle_count  out  CNT_W  run cycles.
- test_id  out  4  cpu_instr[31:28] captured at STOP.
- timeout  out  1  run hit TIMEOUT.
- done  out  1  sequence complete.

Behaviour:
- Reset: every output is 0; state IDLE; internal index 0.
- Reset is honoured at any time, mid-operation included: immediate return to IDLE; partially written memory is not restored.
- IDLE:
  - start -> LOAD_D; clears done, timeout, cycle_count, test_id; latches dump_base and dump_len.
  - start in any other state is ignored.
- LOAD_D:
  - host_ready=1.
  - Each cycle with host_valid: dmem_wen=1, dmem_addr=idx<<3, dmem_wdata=host_data (combinational from host_data while host_valid).
  - idx increments per accepted word.
  - host_valid=0 stalls with no write.
  - After word DMEM_WORDS-1 -> LOAD_I, idx=0.
- LOAD_I:
  - Same handshake; imem_wen=1, imem_addr=idx<<2, imem_wdata=host_data[31:0].
  - After word IMEM_WORDS-1 -> RUN.
- RUN:
  - cpu_enable=1, registered; first high cycle is the cycle after the last imem write.
  - cycle_count increments every RUN cycle.
  - If cpu_enable=1 and cpu_instr[6:0]==STOP_OPC: capture test_id, drop cpu_enable next cycle, -> DUMP.
  - Else if cycle_count==TIMEOUT: timeout=1, cpu_enable=0, -> DONE with no dump.
  - STOP and timeout in the same cycle: STOP wins, timeout stays 0.
- DUMP:
  - dump_len==0 -> DONE directly.
  - Otherwise, per word k, issue dmem_ren=1 with dmem_addr=(dump_base+k)<<3 for one cycle.
  - dmem_rdata is valid the following cycle; register it into out_data and set out_valid=1.
  - Hold out_data stable while out_ready=0.
  - On a valid&ready cycle, issue the next read; throughput is 1 word per 2 cycles minimum.
  - Index wraps modulo DMEM_WORDS: 7-bit add, base 126 with len 4 reads 126,127,0,1.
  - After the last handshake -> DONE.
- DONE: done=1 and sticky; results held until the next start, which re-enters LOAD_D.
- Host writes and dmem reads never coincide; at most one of dmem_wen/dmem_ren is high in any cycle.

Decomposition:
- Package mem_boot_pkg:
  - state encoding: IDLE, LOAD_D, LOAD_I, RUN, DUMP_RD, DUMP_OUT, DONE.
  - STOP_OPC; address shift constants 2 and 3.
- One sub-module, boot_run_monitor: cycle counter, STOP/timeout compare, test_id capture.
- The FSM and memory muxing stay in the top.

Test Plan:
- Load of 128 dmem words (value i) and 128 imem words with STOP 0x0000007E at imem[5] -> dmem writes at addr 0..0x3F8; cpu_enable rises the cycle after the imem[127] write; done=1; test_id=0.
- host_valid toggled every other cycle during load -> exactly 256 writes, no duplicate or skipped addresses.
- STOP 0x4000007E with dump_base=50, dump_len=24, out_ready random -> test_id=4; 24 words in order equal to dmem[50..73]; out_data stable while stalled.
- Image with no STOP, TIMEOUT=20 -> timeout=1, cycle_count=20, no dmem_ren, done=1.
- dump_base=126, dump_len=4 -> read addresses 0x3F0, 0x3F8, 0x000, 0x008; dump_len=0 -> done with no out_valid.
- arst pulsed during LOAD_I, then start again -> all outputs 0 after reset; reload completes normally; start pulsed during RUN is ignored.

Source files
------------

// File: rtl/mem_boot_pkg.sv
// Shared types and constants for the memory boot sequencer.
package mem_boot_pkg;

    localparam int unsigned IDX_W      = 8;
    localparam int unsigned IMEM_SHIFT = 2;
    localparam int unsigned DMEM_SHIFT = 3;
    localparam logic [6:0]  STOP_OPC   = 7'b1111110;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        LOAD_I,
        RUN,
        DUMP_RD,
        DUMP_OUT,
        DONE
    } state_e;

    // Dump word address; the word index wraps within the 7-bit dmem index space.
    function automatic logic [63:0] dump_addr(input logic [6:0] base, input logic [7:0] k);
        logic [6:0] w;
        w = base + k[6:0];
        return 64'(w) << DMEM_SHIFT;
    endfunction

endpackage

// File: rtl/boot_run_monitor.sv
// Run-phase monitor: cycle counter, STOP/timeout detection and test_id capture.
module boot_run_monitor import mem_boot_pkg::*; #(
    parameter int unsigned TIMEOUT = 99999,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             run,
    input  logic             cpu_enable,
    input  logic [31:0]      cpu_instr,
    output logic             stop_c,
    output logic             tmo_c,
    output logic [CNT_W-1:0] cycle_count,
    output logic [3:0]       test_id,
    output logic             timeout
);

    logic unused_instr;
    assign unused_instr = ^cpu_instr[27:7];

    // STOP takes priority over a coincident timeout.
    assign stop_c = run && cpu_enable && (cpu_instr[6:0] == STOP_OPC);
    assign tmo_c  = run && !stop_c && (cycle_count == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cycle_count <= '0;
            test_id     <= '0;
            timeout     <= 1'b0;
        end else if (clr) begin
            cycle_count <= '0;
            test_id     <= '0;
            timeout     <= 1'b0;
        end else begin
            if (run && !stop_c && !tmo_c) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (stop_c) begin
                test_id <= cpu_instr[31:28];
            end
            if (tmo_c) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_boot_seq.sv
// Boot sequencer: loads dmem then imem from the host, runs the cpu, dumps a dmem window.
module mem_boot_seq import mem_boot_pkg::*; #(
    parameter int unsigned IMEM_WORDS = 128,
    parameter int unsigned DMEM_WORDS = 128,
    parameter int unsigned TIMEOUT    = 99999,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [6:0]       dump_base,
    input  logic [7:0]       dump_len,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [63:0]      host_data,
    output logic             imem_wen,
    output logic [63:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             dmem_wen,
    output logic             dmem_ren,
    output logic [63:0]      dmem_addr,
    output logic [63:0]      dmem_wdata,
    input  logic [63:0]      dmem_rdata,
    input  logic [31:0]      cpu_instr,
    output logic             cpu_enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [3:0]       test_id,
    output logic             timeout,
    output logic             done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       k_q, k_d, len_q, len_d;
    logic [6:0]       base_q, base_d;
    logic [63:0]      out_data_d;
    logic             out_valid_d, cpu_enable_d, done_d;
    logic             clr_c, run_c, stop_c, tmo_c;

    assign run_c = (state_q == RUN);

    boot_run_monitor #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_run_monitor (
        .clk         (clk),
        .arst        (arst),
        .clr         (clr_c),
        .run         (run_c),
        .cpu_enable  (cpu_enable),
        .cpu_instr   (cpu_instr),
        .stop_c      (stop_c),
        .tmo_c       (tmo_c),
        .cycle_count (cycle_count),
        .test_id     (test_id),
        .timeout     (timeout)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            k_q        <= '0;
            len_q      <= '0;
            base_q     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            cpu_enable <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            len_q      <= len_d;
            base_q     <= base_d;
            out_data   <= out_data_d;
            out_valid  <= out_valid_d;
            cpu_enable <= cpu_enable_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        k_d          = k_q;
        len_d        = len_q;
        base_d       = base_q;
        out_data_d   = out_data;
        out_valid_d  = out_valid;
        cpu_enable_d = cpu_enable;
        done_d       = done;
        clr_c        = 1'b0;
        host_ready   = 1'b0;
        imem_wen     = 1'b0;
        imem_addr    = '0;
        imem_wdata   = '0;
        dmem_wen     = 1'b0;
        dmem_ren     = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD_D;
                    idx_d   = '0;
                    k_d     = '0;
                    base_d  = dump_base;
                    len_d   = dump_len;
                    done_d  = 1'b0;
                    clr_c   = 1'b1;
                end
            end
            LOAD_D: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    dmem_wen   = 1'b1;
                    dmem_addr  = 64'(idx_q) << DMEM_SHIFT;
                    dmem_wdata = host_data;
                    if (idx_q == IDX_W'(DMEM_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = LOAD_I;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD_I: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    imem_wen   = 1'b1;
                    imem_addr  = 64'(idx_q) << IMEM_SHIFT;
                    imem_wdata = host_data[31:0];
                    if (idx_q == IDX_W'(IMEM_WORDS - 1)) begin
                        idx_d        = '0;
                        state_d      = RUN;
                        cpu_enable_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                if (stop_c) begin
                    cpu_enable_d = 1'b0;
                    if (len_q == 8'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DUMP_RD;
                    end
                end else if (tmo_c) begin
                    cpu_enable_d = 1'b0;
                    state_d      = DONE;
                    done_d       = 1'b1;
                end
            end
            DUMP_RD: begin
                dmem_ren  = 1'b1;
                dmem_addr = dump_addr(base_q, k_q);
                state_d   = DUMP_OUT;
            end
            DUMP_OUT: begin
                // out_valid low here means read data arrives this cycle.
                if (!out_valid) begin
                    out_data_d  = dmem_rdata;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (k_q == len_q - 8'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        k_d       = k_q + 8'd1;
                        dmem_ren  = 1'b1;
                        dmem_addr = dump_addr(base_q, k_q + 8'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_boot_seq.sv
// Scoreboard bench for mem_boot_seq with a small cpu/memory model on the external ports.
module tb_mem_boot_seq;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        arst, start, host_valid, host_ready, out_ready;
    logic [6:0]  dump_base;
    logic [7:0]  dump_len;
    logic [63:0] host_data;
    logic        imem_wen, dmem_wen, dmem_ren, cpu_enable, out_valid, timeout, done;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, out_data;
    logic [31:0] imem_wdata, cpu_instr, cycle_count;
    logic [3:0]  test_id;

    typedef struct {
        logic        is_i;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] dump_q[$];
    wr_t         wexp;
    logic [63:0] rexp;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr, n_ren, n_outv, n_hs;

    logic [63:0] img_d[128];
    logic [31:0] img_i[128];
    logic [31:0] imem_m[128];
    logic [63:0] dmem_m[128];
    logic [7:0]  pc = 8'd0;
    bit          rand_ready = 1'b0;
    bit          last_i_flag = 1'b0;
    bit          held = 1'b0;
    logic [63:0] held_data;

    always #5 clk = ~clk;

    mem_boot_seq #(
        .IMEM_WORDS (128),
        .DMEM_WORDS (128),
        .TIMEOUT    (TMO),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .start       (start),
        .dump_base   (dump_base),
        .dump_len    (dump_len),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_data   (host_data),
        .imem_wen    (imem_wen),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .dmem_wen    (dmem_wen),
        .dmem_ren    (dmem_ren),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .cpu_instr   (cpu_instr),
        .cpu_enable  (cpu_enable),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cycle_count (cycle_count),
        .test_id     (test_id),
        .timeout     (timeout),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // cpu model: fetches one imem word per enabled cycle from pc 0; dmem reads have one cycle latency
    assign cpu_instr = cpu_enable ? imem_m[pc[6:0]] : 32'h0;

    always @(posedge clk) begin
        if (imem_wen) imem_m[imem_addr[8:2]] <= imem_wdata;
        if (dmem_wen) dmem_m[dmem_addr[9:3]] <= dmem_wdata;
        if (dmem_ren) dmem_rdata <= dmem_m[dmem_addr[9:3]];
        pc <= cpu_enable ? pc + 8'd1 : 8'd0;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (last_i_flag) begin
            check("cpu_en_rise", 64'(cpu_enable), 64'd1);
            last_i_flag = 1'b0;
        end
        if (dmem_wen || imem_wen) begin
            n_wr++;
            check("write_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
                wexp = wr_q.pop_front();
                check("wr_port", 64'(imem_wen), 64'(wexp.is_i));
                check("wr_addr", imem_wen ? imem_addr : dmem_addr, wexp.addr);
                check("wr_data", imem_wen ? {32'h0, imem_wdata} : dmem_wdata, wexp.data);
                if (wexp.is_i && wexp.addr == 64'h1FC) begin
                    check("cpu_en_pre", 64'(cpu_enable), 64'd0);
                    last_i_flag = 1'b1;
                end
            end
        end
        if (dmem_ren) begin
            n_ren++;
            check("ren_excl", 64'(dmem_wen), 64'd0);
            check("read_expected", 64'(rd_q.size() != 0), 64'd1);
            if (rd_q.size() != 0) begin
                rexp = rd_q.pop_front();
                check("rd_addr", dmem_addr, rexp);
            end
        end
        if (held) begin
            check("dump_hold_valid", 64'(out_valid), 64'd1);
            check("dump_hold_data", out_data, held_data);
        end
        if (out_valid) begin
            n_outv++;
            if (out_ready) begin
                n_hs++;
                check("dump_expected", 64'(dump_q.size() != 0), 64'd1);
                if (dump_q.size() != 0) begin
                    rexp = dump_q.pop_front();
                    check("dump_data", out_data, rexp);
                end
            end
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_host_ready"}, 64'(host_ready), 64'd0);
        check({tag, "_imem_wen"}, 64'(imem_wen), 64'd0);
        check({tag, "_dmem_wen"}, 64'(dmem_wen), 64'd0);
        check({tag, "_dmem_ren"}, 64'(dmem_ren), 64'd0);
        check({tag, "_dmem_addr"}, dmem_addr, 64'd0);
        check({tag, "_cpu_enable"}, 64'(cpu_enable), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
        check({tag, "_test_id"}, 64'(test_id), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic build_image(input int seed, input int stop_pos, input logic [31:0] stop_word);
        for (int i = 0; i < 128; i++) begin
            img_d[i] = (seed == 0) ? 64'(i) : {32'(seed) | 32'hD000_0000, 32'(i)};
            img_i[i] = {20'(i + seed), 12'h013};
        end
        if (stop_pos >= 0) img_i[stop_pos] = stop_word;
    endtask

    task automatic pulse_start(input logic [6:0] base, input logic [7:0] len);
        @(posedge clk); #1;
        start = 1'b1; dump_base = base; dump_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load(input bit gap, input int n_words);
        wr_t w;
        bit  hs;
        int  tries;
        for (int i = 0; i < n_words; i++) begin
            if (i < 128) begin
                w.is_i = 1'b0; w.addr = 64'(i) << 3; w.data = img_d[i];
                host_data = img_d[i];
            end else begin
                w.is_i = 1'b1; w.addr = 64'(i - 128) << 2; w.data = 64'(img_i[i - 128]);
                host_data = {32'hDEAD_BEEF, img_i[i - 128]};
            end
            wr_q.push_back(w);
            host_valid = 1'b1;
            tries = 0;
            do begin
                @(negedge clk);
                hs = host_ready;
                @(posedge clk); #1;
                tries++;
            end while (!hs && tries < 50);
            if (!hs) check("host_ready_wait", 64'(hs), 64'd1);
            host_valid = 1'b0;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
        host_valid = 1'b0;
    endtask

    task automatic boot(input bit gap, input int seed, input int stop_pos, input logic [31:0] stop_word,
                        input logic [6:0] base, input logic [7:0] len, input bit exp_tmo,
                        input bit run_start);
        int t;
        int idx;
        build_image(seed, stop_pos, stop_word);
        n_wr = 0; n_ren = 0; n_outv = 0; n_hs = 0;
        pulse_start(base, len);
        load(gap, 256);
        if (!exp_tmo) begin
            for (int k = 0; k < int'(len); k++) begin
                idx = (int'(base) + k) % 128;
                rd_q.push_back(64'(idx) << 3);
                dump_q.push_back(img_d[idx]);
            end
        end
        if (run_start) begin
            t = 0;
            while (!cpu_enable && t < 50) begin @(negedge clk); t++; end
            check("run_seen", 64'(cpu_enable), 64'd1);
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        t = 0;
        while (!done && t < 3000) begin @(negedge clk); t++; end
        check("done", 64'(done), 64'd1);
        check("test_id", 64'(test_id), exp_tmo ? 64'd0 : 64'(stop_word[31:28]));
        check("timeout", 64'(timeout), 64'(exp_tmo));
        check("cpu_en_off", 64'(cpu_enable), 64'd0);
        check("write_count", 64'(n_wr), 64'd256);
        check("read_count", 64'(n_ren), exp_tmo ? 64'd0 : 64'(len));
        check("handshake_count", 64'(n_hs), exp_tmo ? 64'd0 : 64'(len));
        if (exp_tmo || len == 8'd0) check("out_valid_cycles", 64'(n_outv), 64'd0);
        if (exp_tmo) check("cycle_count", 64'(cycle_count), 64'(TMO));
        check("wr_q_left", 64'(wr_q.size()), 64'd0);
        check("rd_q_left", 64'(rd_q.size()), 64'd0);
        check("dump_q_left", 64'(dump_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        arst = 1'b1; start = 1'b0; host_valid = 1'b0; host_data = '0;
        dump_base = '0; dump_len = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        @(posedge clk); #1; arst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_rst");

        // value-i image, STOP at imem[5], empty dump
        boot(1'b0, 0, 5, 32'h0000_007E, 7'd0, 8'd0, 1'b0, 1'b0);

        // gapped host stream, randomly stalled dump of dmem[50..73]
        rand_ready = 1'b1;
        boot(1'b1, 3, 9, 32'h4000_007E, 7'd50, 8'd24, 1'b0, 1'b0);
        rand_ready = 1'b0;

        // no STOP in the image: run ends on timeout, no dump
        boot(1'b0, 5, -1, 32'h0, 7'd0, 8'd8, 1'b1, 1'b0);

        // STOP on the timeout cycle, dump wrapping past index 127
        boot(1'b0, 7, TMO, 32'h7000_007E, 7'd126, 8'd4, 1'b0, 1'b0);

        // reset in the middle of the imem load
        build_image(9, 3, 32'h2000_007E);
        pulse_start(7'd10, 8'd2);
        load(1'b0, 138);
        @(posedge clk); #1; arst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_rst");
        check("mid_rst_wr_q", 64'(wr_q.size()), 64'd0);
        @(posedge clk); #1; arst = 1'b0;

        // full reload with a start pulse during RUN that must be ignored
        boot(1'b0, 9, 3, 32'h2000_007E, 7'd10, 8'd2, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
